// File: rtl/branch_resolve_queue.sv
// In-order resolve queue for predicted RV32I conditional branches: CDB operand capture,
// oldest-first resolution, predictor update and mispredict redirect. Optional BRQ_STATS_EN adds counters.
module branch_resolve_queue #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DEPTH_W = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        alloc_valid,
  input  logic [2:0]  alloc_funct3,
  input  logic [31:0] alloc_pc,
  input  logic [31:0] alloc_imm,
  input  logic        alloc_taken,
  input  logic [3:0]  alloc_rs1_tag,
  input  logic [3:0]  alloc_rs2_tag,
  input  logic [31:0] alloc_rs1_val,
  input  logic [31:0] alloc_rs2_val,
  input  logic [3:0]  cdb_tag,
  input  logic [31:0] cdb_val,
  output logic        full_out,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic        upd_taken,
  output logic        predict_fail,
  output logic [31:0] redirect_addr
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned CNT_W = DEPTH_W + 1;

  typedef struct packed {
    logic             valid;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             pred;
    logic [TAG_W-1:0] rs1_tag;
    logic [XLEN-1:0]  rs1_val;
    logic [TAG_W-1:0] rs2_tag;
    logic [XLEN-1:0]  rs2_val;
  } entry_t;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t             state, state_d;
  entry_t             q [DEPTH];
  entry_t             head_e, alloc_e;
  logic [DEPTH_W-1:0] head, tail;
  logic [CNT_W-1:0]   count, count_d;
  logic               ops_eq, ops_lt, ops_ltu, actual;
  logic               do_resolve, do_alloc, mispred;
  logic [XLEN-1:0]    target;

  assign head_e = q[head];

  // Head evaluation, alloc qualification and FSM next state
  always_comb begin
    state_d    = state;
    ops_eq     = head_e.rs1_val == head_e.rs2_val;
    ops_lt     = $signed(head_e.rs1_val) < $signed(head_e.rs2_val);
    ops_ltu    = head_e.rs1_val < head_e.rs2_val;
    actual     = 1'b0;
    case (head_e.funct3)
      3'b000:  actual = ops_eq;
      3'b001:  actual = !ops_eq;
      3'b100:  actual = ops_lt;
      3'b101:  actual = !ops_lt;
      3'b110:  actual = ops_ltu;
      3'b111:  actual = !ops_ltu;
      default: actual = 1'b0;
    endcase
    do_resolve = (state == ST_RUN) && head_e.valid &&
                 (head_e.rs1_tag == '0) && (head_e.rs2_tag == '0);
    mispred    = do_resolve && (actual != head_e.pred);
    do_alloc   = alloc_valid && !full_out && !predict_fail && (state == ST_RUN) && !mispred;
    target     = actual ? (head_e.pc + head_e.imm) : (head_e.pc + XLEN'(4));
    case (state)
      ST_RUN:   if (mispred) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Occupancy after this edge
  always_comb begin
    count_d = count;
    if (mispred)                     count_d = '0;
    else if (do_alloc && !do_resolve) count_d = count + CNT_W'(1);
    else if (!do_alloc && do_resolve) count_d = count - CNT_W'(1);
  end

  // New entry, snooping the CDB in the same cycle
  always_comb begin
    alloc_e         = '0;
    alloc_e.valid   = 1'b1;
    alloc_e.funct3  = alloc_funct3;
    alloc_e.pc      = alloc_pc;
    alloc_e.imm     = alloc_imm;
    alloc_e.pred    = alloc_taken;
    alloc_e.rs1_tag = alloc_rs1_tag;
    alloc_e.rs1_val = alloc_rs1_val;
    alloc_e.rs2_tag = alloc_rs2_tag;
    alloc_e.rs2_val = alloc_rs2_val;
    if ((cdb_tag != '0) && (alloc_rs1_tag == cdb_tag)) begin
      alloc_e.rs1_tag = '0;
      alloc_e.rs1_val = cdb_val;
    end
    if ((cdb_tag != '0) && (alloc_rs2_tag == cdb_tag)) begin
      alloc_e.rs2_tag = '0;
      alloc_e.rs2_val = cdb_val;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= ST_RUN;
    else if (rdy_in) state <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      full_out      <= 1'b0;
      upd_valid     <= 1'b0;
      upd_pc        <= '0;
      upd_taken     <= 1'b0;
      predict_fail  <= 1'b0;
      redirect_addr <= '0;
    end else if (rdy_in) begin
      upd_valid     <= do_resolve;
      upd_pc        <= do_resolve ? head_e.pc : '0;
      upd_taken     <= do_resolve && actual;
      predict_fail  <= mispred;
      redirect_addr <= mispred ? target : '0;
      count         <= count_d;
      full_out      <= count_d == CNT_W'(DEPTH);
      if (mispred) begin
        for (int i = 0; i < int'(DEPTH); i++) q[i].valid <= 1'b0;
        head <= '0;
        tail <= '0;
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (q[i].valid && (cdb_tag != '0)) begin
            if (q[i].rs1_tag == cdb_tag) begin
              q[i].rs1_tag <= '0;
              q[i].rs1_val <= cdb_val;
            end
            if (q[i].rs2_tag == cdb_tag) begin
              q[i].rs2_tag <= '0;
              q[i].rs2_val <= cdb_val;
            end
          end
        end
        // Tail slot is never valid when an alloc is accepted, so this cannot clash with the snoop
        if (do_resolve) begin
          q[head].valid <= 1'b0;
          head          <= head + DEPTH_W'(1);
        end
        if (do_alloc) begin
          q[tail] <= alloc_e;
          tail    <= tail + DEPTH_W'(1);
        end
      end
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else if (rdy_in) begin
      if (do_resolve) stat_resolved <= stat_resolved + 32'd1;
      if (mispred)    stat_mispred  <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: vector table, directed multi-cycle sequences and
// randomized traffic checked against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        alloc_valid, alloc_taken;
  logic [2:0]  alloc_funct3;
  logic [31:0] alloc_pc, alloc_imm, alloc_rs1_val, alloc_rs2_val, cdb_val;
  logic [3:0]  alloc_rs1_tag, alloc_rs2_tag, cdb_tag;
  logic        full_out, upd_valid, upd_taken, predict_fail;
  logic [31:0] upd_pc, redirect_addr;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
`endif

  branch_resolve_queue #(.DEPTH(8), .DEPTH_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_funct3(alloc_funct3), .alloc_pc(alloc_pc),
    .alloc_imm(alloc_imm), .alloc_taken(alloc_taken),
    .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
    .alloc_rs1_val(alloc_rs1_val), .alloc_rs2_val(alloc_rs2_val),
    .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .full_out(full_out), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .predict_fail(predict_fail), .redirect_addr(redirect_addr)
`ifdef BRQ_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] pc, imm, t1, v1, t2, v2;
    logic        pred;
  } m_entry_t;

  m_entry_t    mq[$];
  logic        m_flush, e_full, e_upd_valid, e_upd_taken, e_pf;
  logic [31:0] e_upd_pc, e_redir, e_res_cnt, e_mis_cnt;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, pc, imm;
    logic        pred, exp_taken, exp_fail;
    logic [31:0] exp_redir;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_flush = 0; e_full = 0; e_upd_valid = 0; e_upd_taken = 0; e_pf = 0;
    e_upd_pc = 0; e_redir = 0; e_res_cnt = 0; e_mis_cnt = 0;
  endtask

  // One clock edge of the reference behaviour, using the currently driven inputs
  task automatic model_edge();
    m_entry_t e;
    logic act, mis, acc;
    if (!rdy_in) return;
    mis = 0;
    acc = alloc_valid && !e_full && !m_flush;
    e_upd_valid = 0; e_upd_pc = 0; e_upd_taken = 0; e_pf = 0; e_redir = 0;
    if (!m_flush && mq.size() > 0 && mq[0].t1 == 0 && mq[0].t2 == 0) begin
      e = mq.pop_front();
      act = ref_taken(e.f3, e.v1, e.v2);
      e_upd_valid = 1; e_upd_pc = e.pc; e_upd_taken = act;
      e_res_cnt = e_res_cnt + 1;
      if (act != e.pred) begin
        mis = 1; e_pf = 1;
        e_redir = act ? e.pc + e.imm : e.pc + 32'd4;
        e_mis_cnt = e_mis_cnt + 1;
        mq.delete();
      end
    end
    foreach (mq[i]) begin
      if (cdb_tag != 0 && mq[i].t1 == 32'(cdb_tag)) begin mq[i].t1 = 0; mq[i].v1 = cdb_val; end
      if (cdb_tag != 0 && mq[i].t2 == 32'(cdb_tag)) begin mq[i].t2 = 0; mq[i].v2 = cdb_val; end
    end
    if (acc && !mis) begin
      e.f3 = alloc_funct3; e.pc = alloc_pc; e.imm = alloc_imm; e.pred = alloc_taken;
      e.t1 = 32'(alloc_rs1_tag); e.v1 = alloc_rs1_val;
      e.t2 = 32'(alloc_rs2_tag); e.v2 = alloc_rs2_val;
      if (cdb_tag != 0 && e.t1 == 32'(cdb_tag)) begin e.t1 = 0; e.v1 = cdb_val; end
      if (cdb_tag != 0 && e.t2 == 32'(cdb_tag)) begin e.t2 = 0; e.v2 = cdb_val; end
      mq.push_back(e);
    end
    m_flush = mis;
    e_full  = (mq.size() == DEPTH);
  endtask

  task automatic check_all();
    chk("full_out", 32'(full_out), 32'(e_full));
    chk("upd_valid", 32'(upd_valid), 32'(e_upd_valid));
    chk("predict_fail", 32'(predict_fail), 32'(e_pf));
    if (e_upd_valid) begin
      chk("upd_pc", upd_pc, e_upd_pc);
      chk("upd_taken", 32'(upd_taken), 32'(e_upd_taken));
    end
    if (e_pf) chk("redirect_addr", redirect_addr, e_redir);
`ifdef BRQ_STATS_EN
    chk("stat_resolved", stat_resolved, e_res_cnt);
    chk("stat_mispred", stat_mispred, e_mis_cnt);
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    check_all();
  endtask

  task automatic set_alloc(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                           input logic pred, input logic [3:0] t1, input logic [31:0] v1,
                           input logic [3:0] t2, input logic [31:0] v2);
    alloc_valid = 1; alloc_funct3 = f3; alloc_pc = pc; alloc_imm = imm; alloc_taken = pred;
    alloc_rs1_tag = t1; alloc_rs1_val = v1; alloc_rs2_tag = t2; alloc_rs2_val = v2;
  endtask

  task automatic clear_alloc();
    alloc_valid = 0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return 32'($urandom_range(0, 3));
    endcase
  endfunction

  function automatic logic [3:0] rand_tag();
    if ($urandom_range(0, 1) == 0) return 4'd0;
    return 4'($urandom_range(1, 7));
  endfunction

  initial begin
    vecs[0] = '{3'b000, 32'd5,          32'd5,          32'h100,      32'h20, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{3'b100, 32'hFFFF_FFFF,  32'd1,          32'h200,      32'h40, 1'b0, 1'b1, 1'b1, 32'h240};
    vecs[2] = '{3'b111, 32'hFFFF_FFFF,  32'd1,          32'h300,      32'h10, 1'b0, 1'b1, 1'b1, 32'h310};
    vecs[3] = '{3'b001, 32'd3,          32'd3,          32'h400,      32'h8,  1'b1, 1'b0, 1'b1, 32'h404};
    vecs[4] = '{3'b101, 32'hFFFF_FFFB,  32'd2,          32'h480,      32'h8,  1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{3'b110, 32'd1,          32'hFFFF_FFFF,  32'h4C0,      32'h8,  1'b1, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{3'b010, 32'd9,          32'd9,          32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{3'b000, 32'd7,          32'd7,          32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1, 1'b1, 32'h10};

    rst_in = 0; rdy_in = 1; alloc_valid = 0; alloc_funct3 = 0; alloc_pc = 0; alloc_imm = 0;
    alloc_taken = 0; alloc_rs1_tag = 0; alloc_rs2_tag = 0; alloc_rs1_val = 0; alloc_rs2_val = 0;
    cdb_tag = 0; cdb_val = 0;
    model_reset();
    #12;
    chk("reset_full", 32'(full_out), 32'd0);
    chk("reset_upd_valid", 32'(upd_valid), 32'd0);
    chk("reset_predict_fail", 32'(predict_fail), 32'd0);
    chk("reset_redirect", redirect_addr, 32'd0);
    rst_in = 1;

    // Table of single-branch vectors, one alloc each with ready operands
    for (int k = 0; k < 8; k++) begin
      set_alloc(vecs[k].f3, vecs[k].pc, vecs[k].imm, vecs[k].pred, 4'd0, vecs[k].a, 4'd0, vecs[k].b);
      step();
      clear_alloc();
      step();
      chk("vec_upd_valid", 32'(upd_valid), 32'd1);
      chk("vec_upd_pc", upd_pc, vecs[k].pc);
      chk("vec_upd_taken", 32'(upd_taken), 32'(vecs[k].exp_taken));
      chk("vec_predict_fail", 32'(predict_fail), 32'(vecs[k].exp_fail));
      if (vecs[k].exp_fail) begin
        chk("vec_redirect", redirect_addr, vecs[k].exp_redir);
        set_alloc(3'b000, 32'hBAD0, 32'h4, 1'b1, 4'd0, 32'd1, 4'd0, 32'd1);
        step();
        clear_alloc();
        chk("flush_empty", 32'(full_out), 32'd0);
        step();
        chk("flush_alloc_dropped", 32'(upd_valid), 32'd0);
      end
    end

    // Operand arrives on the CDB two cycles after alloc
    set_alloc(3'b001, 32'h500, 32'h10, 1'b1, 4'd3, 32'hDEAD, 4'd0, 32'd0);
    step();
    clear_alloc();
    step();
    chk("cdb_wait1", 32'(upd_valid), 32'd0);
    step();
    cdb_tag = 4'd3; cdb_val = 32'd5;
    step();
    cdb_tag = 4'd0;
    chk("cdb_no_early", 32'(upd_valid), 32'd0);
    step();
    chk("cdb_resolve", 32'(upd_valid), 32'd1);
    chk("cdb_taken", 32'(upd_taken), 32'd1);
    chk("cdb_no_fail", 32'(predict_fail), 32'd0);

    // Alloc and matching broadcast in the same cycle
    set_alloc(3'b000, 32'h600, 32'h8, 1'b1, 4'd2, 32'd0, 4'd0, 32'd9);
    cdb_tag = 4'd2; cdb_val = 32'd9;
    step();
    clear_alloc(); cdb_tag = 4'd0;
    step();
    chk("same_cycle_resolve", 32'(upd_valid), 32'd1);
    chk("same_cycle_taken", 32'(upd_taken), 32'd1);
    chk("same_cycle_no_fail", 32'(predict_fail), 32'd0);

    // Fill all entries with pending operands (pointers start mid-ring, so they wrap)
    for (int k = 0; k < 8; k++) begin
      set_alloc(3'b000, 32'h1000 + 32'(4 * k), 32'h40, 1'b1, 4'd7, 32'd0, 4'd0, 32'h77);
      step();
    end
    chk("fill_full", 32'(full_out), 32'd1);
    set_alloc(3'b000, 32'h2000, 32'h40, 1'b1, 4'd0, 32'h77, 4'd0, 32'h77);
    step();
    chk("ninth_dropped_full", 32'(full_out), 32'd1);
    clear_alloc();
    cdb_tag = 4'd7; cdb_val = 32'h77;
    step();
    cdb_tag = 4'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("drain_valid", 32'(upd_valid), 32'd1);
      chk("drain_order", upd_pc, 32'h1000 + 32'(4 * k));
      if (k == 0) chk("drain_full_freed", 32'(full_out), 32'd0);
    end
    step();
    chk("drain_empty", 32'(upd_valid), 32'd0);

    // Unsigned mispredict, then freeze with rdy_in low
    set_alloc(3'b111, 32'h700, 32'h30, 1'b0, 4'd0, 32'hFFFF_FFFF, 4'd0, 32'd1);
    step();
    clear_alloc();
    step();
    chk("bgeu_fail", 32'(predict_fail), 32'd1);
    chk("bgeu_redirect", redirect_addr, 32'h730);
    rdy_in = 0;
    set_alloc(3'b000, 32'h740, 32'h4, 1'b1, 4'd0, 32'd1, 4'd0, 32'd1);
    cdb_tag = 4'd4; cdb_val = 32'h55;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("freeze_fail", 32'(predict_fail), 32'd1);
      chk("freeze_redirect", redirect_addr, 32'h730);
      chk("freeze_upd_pc", upd_pc, 32'h700);
    end
    rdy_in = 1; cdb_tag = 4'd0;
    step();
    chk("unfreeze_fail_drop", 32'(predict_fail), 32'd0);
    clear_alloc();
    step();
    chk("unfreeze_alloc_dropped", 32'(upd_valid), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy_in        = ($urandom_range(0, 9) != 0);
      alloc_valid   = 1'($urandom_range(0, 1));
      alloc_funct3  = 3'($urandom_range(0, 7));
      alloc_pc      = $urandom & 32'hFFFF_FFFC;
      alloc_imm     = rand_val();
      alloc_taken   = 1'($urandom_range(0, 1));
      alloc_rs1_tag = rand_tag();
      alloc_rs2_tag = rand_tag();
      alloc_rs1_val = rand_val();
      alloc_rs2_val = rand_val();
      cdb_tag       = 4'($urandom_range(0, 7));
      cdb_val       = rand_val();
      step();
    end

    // Clean restart, then async reset with four entries pending
    rdy_in = 1; clear_alloc(); cdb_tag = 0;
    rst_in = 0;
    #2;
    model_reset();
    #4;
    rst_in = 1;
    set_alloc(3'b000, 32'h800, 32'h4, 1'b1, 4'd6, 32'd0, 4'd0, 32'h11);
    step();
    for (int k = 0; k < 4; k++) begin
      set_alloc(3'b000, 32'h900 + 32'(4 * k), 32'h4, 1'b1, 4'd5, 32'd0, 4'd0, 32'd0);
      if (k == 3) begin cdb_tag = 4'd6; cdb_val = 32'h11; end
      step();
    end
    clear_alloc(); cdb_tag = 0;
    step();
    chk("pre_reset_valid", 32'(upd_valid), 32'd1);
    chk("pre_reset_pc", upd_pc, 32'h800);
    #2;
    rst_in = 0;
    #1;
    chk("async_upd_valid", 32'(upd_valid), 32'd0);
    chk("async_upd_pc", upd_pc, 32'd0);
    chk("async_full", 32'(full_out), 32'd0);
    chk("async_fail", 32'(predict_fail), 32'd0);
`ifdef BRQ_STATS_EN
    chk("async_stat_resolved", stat_resolved, 32'd0);
    chk("async_stat_mispred", stat_mispred, 32'd0);
`endif
    model_reset();
    @(posedge clk_in);
    #2;
    rst_in = 1;
    set_alloc(3'b000, 32'hA00, 32'h4, 1'b1, 4'd0, 32'd3, 4'd0, 32'd3);
    step();
    clear_alloc();
    step();
    chk("post_reset_resolve", 32'(upd_valid), 32'd1);
    chk("post_reset_pc", upd_pc, 32'hA00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
